// File: rtl/sp_mem_responder_pkg.sv
// Shared types and helpers for the single-port memory responder.
// The lane-merge helper works on a maximum-width word so any DATA_WIDTH up to MAX_DATA_WIDTH can use it.
package mem_pkg;

  localparam int LANE_WIDTH     = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int NUM_LANES      = DEF_DATA_WIDTH / LANE_WIDTH;
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_LANES      = MAX_DATA_WIDTH / LANE_WIDTH;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
  typedef logic [NUM_LANES-1:0]      lane_mask_t;
  typedef logic [MAX_DATA_WIDTH-1:0] wide_word_t;
  typedef logic [MAX_LANES-1:0]      wide_mask_t;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    word_t                     wdata;
    logic                      we;
    lane_mask_t                be;
  } mem_req_t;

  // Replace each byte lane of old_word whose mask bit is set with the matching lane of new_word.
  function automatic wide_word_t apply_byte_mask(input wide_word_t old_word,
                                                 input wide_word_t new_word,
                                                 input wide_mask_t mask);
    wide_word_t merged;
    merged = old_word;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (mask[i]) begin
        merged[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
      end else begin
        merged[i*LANE_WIDTH +: LANE_WIDTH] = old_word[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sp_mem_responder_if.sv
// Single-port memory interface: request fields from the master, read data back from the slave.
interface MemoryInterfaceSinglePort
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] address;
  logic                  write_enable;
  logic [LANES-1:0]      enable;
  logic [LANES-1:0]      byte_enable;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output write_data, address, write_enable, enable, byte_enable,
    input  read_data
  );

  modport slave (
    input  write_data, address, write_enable, enable, byte_enable,
    output read_data
  );

endinterface

// File: rtl/sp_mem_responder_chk.sv
// Simulation-only parameter and input sanity checks for sp_mem_responder.
module sp_mem_responder_chk
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int LANES        = DATA_WIDTH / LANE_WIDTH
) (
  input logic             clk,
  input logic             rst,
  input logic [LANES-1:0] enable,
  input logic             write_enable
);

  // Configuration legality and X-free control inputs outside reset.
  always_ff @(posedge clk) begin
    assert (READ_LATENCY >= 1 && READ_LATENCY <= 4)
      else $error("sp_mem_responder: READ_LATENCY %0d outside 1..4", READ_LATENCY);
    assert ((DATA_WIDTH % LANE_WIDTH) == 0 && DATA_WIDTH <= MAX_DATA_WIDTH)
      else $error("sp_mem_responder: DATA_WIDTH %0d not a byte multiple within range", DATA_WIDTH);
    assert (64'(DEPTH) <= (64'd1 << ADDR_WIDTH))
      else $error("sp_mem_responder: DEPTH %0d exceeds address space", DEPTH);
    if (!rst) begin
      assert (!$isunknown(enable))
        else $error("sp_mem_responder: X on enable");
      assert (!$isunknown(write_enable))
        else $error("sp_mem_responder: X on write_enable");
    end
  end

endmodule

// File: rtl/sp_mem_responder_read_pipe.sv
// Read-result delay line of {valid, err, data}; reset clears the valid/err bits and the output word.
// Data stages only load when a valid result enters them, so the output word holds between results.
module mem_read_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_err,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [LATENCY-1:0]    r_valid;
  logic [LATENCY-1:0]    r_err;
  logic [DATA_WIDTH-1:0] r_data [LATENCY];

  // Shift the valid/err flags; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_err   <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_err[0]   <= i_err;
      for (int k = 1; k < LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_err[k]   <= r_err[k-1];
      end
    end
  end

  // Advance data only alongside a valid flag; the last stage is the visible read_data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data[LATENCY-1] <= '0;
    end else begin
      if (i_valid) begin
        r_data[0] <= i_data;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (r_valid[k-1]) begin
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_err   = r_err[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/sp_mem_responder.sv
// Slave-end responder for MemoryInterfaceSinglePort: byte-lane writes into a word array and
// reads returned through a READ_LATENCY-deep pipe, with read_valid/addr_error side pulses.
module sp_mem_responder
  import mem_pkg::*;
#(
  parameter int    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int    DEPTH        = 1024,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  MemoryInterfaceSinglePort.slave  mem,
  output logic                     read_valid,
  output logic                     addr_error
);

  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  w_req;
  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_pipe_data;
  logic                  w_pipe_valid;
  logic                  w_pipe_err;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Decode the request; the index is only trusted once the zero-extended range check passes.
  always_comb begin
    w_req      = |mem.enable;
    w_in_range = ({1'b0, mem.address} < DEPTH_EXT);
    w_accept   = !rst && w_req;
    w_wr       = w_accept && mem.write_enable && w_in_range;
    w_rd       = w_accept && !mem.write_enable;
    w_err      = w_accept && !w_in_range;
    w_idx      = mem.address[IDX_W-1:0];
    w_rd_word  = w_in_range ? r_mem[w_idx] : '0;
  end

  assign w_merged = DATA_WIDTH'(apply_byte_mask(wide_word_t'(r_mem[w_idx]),
                                                wide_word_t'(mem.write_data),
                                                wide_mask_t'(mem.byte_enable)));

  // Array contents survive reset; only in-range writes land.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  mem_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_rd),
    .i_err   (w_err),
    .i_data  (w_rd_word),
    .o_valid (w_pipe_valid),
    .o_err   (w_pipe_err),
    .o_data  (w_pipe_data)
  );

  assign mem.read_data = w_pipe_data;
  assign read_valid    = w_pipe_valid;
  assign addr_error    = w_pipe_err;

  sp_mem_responder_chk #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DEPTH        (DEPTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .enable       (mem.enable),
    .write_enable (mem.write_enable)
  );

endmodule

// File: tb/tb_sp_mem_responder.sv
// Directed bench: one shared request bus drives three responders (READ_LATENCY 1, 2, 3),
// each scenario task checks the instance whose latency it targets.
module tb_sp_mem_responder;

  logic        clk;
  logic        rst1, rst2, rst3;
  logic [3:0]  s_en;
  logic        s_we;
  logic [15:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic        rv1, rv2, rv3;
  logic        ae1, ae2, ae3;
  int          n_vec;
  int          n_miss;

  MemoryInterfaceSinglePort #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) if1 ();
  MemoryInterfaceSinglePort #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) if2 ();
  MemoryInterfaceSinglePort #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) if3 ();

  assign if1.enable = s_en;  assign if1.write_enable = s_we;  assign if1.address = s_addr;
  assign if1.write_data = s_wdata;  assign if1.byte_enable = s_be;
  assign if2.enable = s_en;  assign if2.write_enable = s_we;  assign if2.address = s_addr;
  assign if2.write_data = s_wdata;  assign if2.byte_enable = s_be;
  assign if3.enable = s_en;  assign if3.write_enable = s_we;  assign if3.address = s_addr;
  assign if3.write_data = s_wdata;  assign if3.byte_enable = s_be;

  sp_mem_responder #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst1), .mem(if1), .read_valid(rv1), .addr_error(ae1));
  sp_mem_responder #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst2), .mem(if2), .read_valid(rv2), .addr_error(ae2));
  sp_mem_responder #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst3), .mem(if3), .read_valid(rv3), .addr_error(ae3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] en, input logic we, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    s_en = en; s_we = we; s_addr = a; s_wdata = d; s_be = be;
    tick();
  endtask

  task automatic idle(input int n);
    s_en = 4'h0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req(((i % 2) == 0) ? 4'hF : 4'h0, 1'b0, 16'd5, 32'h0, 4'hF);
      n_vec++; if (rv1 !== 1'b0) begin n_miss++; $display("FAIL reset rv1 cyc %0d: got %b want 0", i, rv1); end
      n_vec++; if (if1.read_data !== 32'h0) begin n_miss++; $display("FAIL reset rd1 cyc %0d: got %h want 0", i, if1.read_data); end
      n_vec++; if (rv3 !== 1'b0 || ae3 !== 1'b0) begin n_miss++; $display("FAIL reset rv3/ae3 cyc %0d: got %b%b want 00", i, rv3, ae3); end
    end
  endtask

  task automatic test_write_read();
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    req(4'hF, 1'b1, 16'd5, 32'hDEADBEEF, 4'hF);
    n_vec++; if (rv1 !== 1'b0 || ae1 !== 1'b0) begin n_miss++; $display("FAIL wr no_valid: got rv=%b ae=%b want 0 0", rv1, ae1); end
    req(4'hF, 1'b0, 16'd5, 32'h0, 4'hF);
    n_vec++; if (rv1 !== 1'b1) begin n_miss++; $display("FAIL rd valid: got %b want 1", rv1); end
    n_vec++; if (if1.read_data !== 32'hDEADBEEF) begin n_miss++; $display("FAIL rd data: got %h want deadbeef", if1.read_data); end
    idle(1);
    n_vec++; if (rv1 !== 1'b0) begin n_miss++; $display("FAIL rd pulse: got %b want 0", rv1); end
    n_vec++; if (if1.read_data !== 32'hDEADBEEF) begin n_miss++; $display("FAIL rd hold: got %h want deadbeef", if1.read_data); end
  endtask

  task automatic test_byte_lanes();
    req(4'hF, 1'b1, 16'd7, 32'h11223344, 4'hF);
    req(4'hF, 1'b1, 16'd7, 32'hAABBCCDD, 4'b0101);
    req(4'b0010, 1'b0, 16'd7, 32'h0, 4'h0);
    n_vec++; if (rv1 !== 1'b1) begin n_miss++; $display("FAIL lanes valid: got %b want 1", rv1); end
    n_vec++; if (if1.read_data !== 32'h11BB33DD) begin n_miss++; $display("FAIL lanes merge: got %h want 11bb33dd", if1.read_data); end
    req(4'hF, 1'b1, 16'd7, 32'hFFFFFFFF, 4'h0);
    n_vec++; if (rv1 !== 1'b0) begin n_miss++; $display("FAIL lanes be0 valid: got %b want 0", rv1); end
    req(4'hF, 1'b0, 16'd7, 32'h0, 4'hF);
    n_vec++; if (if1.read_data !== 32'h11BB33DD || rv1 !== 1'b1) begin n_miss++; $display("FAIL lanes be0 noop: got %h/%b want 11bb33dd/1", if1.read_data, rv1); end
    idle(1);
  endtask

  task automatic test_stream_lat3();
    logic [31:0] tab [4];
    logic        exp_v;
    tab = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    for (int a = 0; a < 4; a++) req(4'hF, 1'b1, 16'(a), tab[a], 4'hF);
    for (int k = 0; k < 7; k++) begin
      if (k < 4) req(4'hF, 1'b0, 16'(k), 32'h0, 4'hF);
      else idle(1);
      exp_v = (k >= 2 && k <= 5);
      n_vec++; if (rv3 !== exp_v) begin n_miss++; $display("FAIL stream valid k=%0d: got %b want %b", k, rv3, exp_v); end
      if (k >= 2) begin
        n_vec++;
        if (if3.read_data !== tab[(k >= 5) ? 3 : (k - 2)]) begin
          n_miss++; $display("FAIL stream data k=%0d: got %h want %h", k, if3.read_data, tab[(k >= 5) ? 3 : (k - 2)]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    req(4'hF, 1'b1, 16'd1023, 32'hCAFEF00D, 4'hF);
    req(4'hF, 1'b1, 16'd1024, 32'h12345678, 4'hF);
    n_vec++; if (ae1 !== 1'b1 || rv1 !== 1'b0) begin n_miss++; $display("FAIL oor wr: got ae=%b rv=%b want 1 0", ae1, rv1); end
    req(4'hF, 1'b0, 16'd0, 32'h0, 4'hF);
    n_vec++; if (if1.read_data !== 32'hA0 || ae1 !== 1'b0) begin n_miss++; $display("FAIL oor untouched: got %h ae=%b want a0 0", if1.read_data, ae1); end
    req(4'hF, 1'b0, 16'd1024, 32'h0, 4'hF);
    n_vec++; if (rv1 !== 1'b1 || ae1 !== 1'b1) begin n_miss++; $display("FAIL oor rd flags: got rv=%b ae=%b want 1 1", rv1, ae1); end
    n_vec++; if (if1.read_data !== 32'h0) begin n_miss++; $display("FAIL oor rd data: got %h want 0", if1.read_data); end
    req(4'hF, 1'b0, 16'hFFFF, 32'h0, 4'hF);
    n_vec++; if (ae1 !== 1'b1 || if1.read_data !== 32'h0) begin n_miss++; $display("FAIL oor ffff: got ae=%b %h want 1 0", ae1, if1.read_data); end
    req(4'hF, 1'b0, 16'd1023, 32'h0, 4'hF);
    n_vec++; if (if1.read_data !== 32'hCAFEF00D || rv1 !== 1'b1 || ae1 !== 1'b0) begin n_miss++; $display("FAIL edge 1023: got %h rv=%b ae=%b want cafef00d 1 0", if1.read_data, rv1, ae1); end
    idle(1);
    n_vec++; if (ae1 !== 1'b0) begin n_miss++; $display("FAIL oor pulse: got %b want 0", ae1); end
  endtask

  task automatic test_reset_mid_flight();
    idle(4);
    req(4'hF, 1'b0, 16'd2, 32'h0, 4'hF);
    rst3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) rst3 = 1'b0;
      idle(1);
      n_vec++; if (rv3 !== 1'b0 || if3.read_data !== 32'h0) begin n_miss++; $display("FAIL midrst k=%0d: got rv=%b %h want 0 0", k, rv3, if3.read_data); end
    end
    req(4'hF, 1'b0, 16'd2, 32'h0, 4'hF);
    n_vec++; if (rv3 !== 1'b0) begin n_miss++; $display("FAIL postrst early1: got %b want 0", rv3); end
    idle(1);
    n_vec++; if (rv3 !== 1'b0) begin n_miss++; $display("FAIL postrst early2: got %b want 0", rv3); end
    idle(1);
    n_vec++; if (rv3 !== 1'b1 || if3.read_data !== 32'hA2) begin n_miss++; $display("FAIL postrst read: got rv=%b %h want 1 a2", rv3, if3.read_data); end
  endtask

  task automatic test_back_to_back_mix();
    logic [5:0] exp_v;
    idle(3);
    exp_v = 6'b010100;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: req(4'hF, 1'b1, 16'd9, 32'h55, 4'hF);
        1: req(4'hF, 1'b0, 16'd9, 32'h0, 4'hF);
        2: req(4'hF, 1'b1, 16'd9, 32'h66, 4'hF);
        3: req(4'hF, 1'b0, 16'd9, 32'h0, 4'hF);
        default: idle(1);
      endcase
      n_vec++; if (rv2 !== exp_v[k]) begin n_miss++; $display("FAIL mix valid k=%0d: got %b want %b", k, rv2, exp_v[k]); end
      if (k >= 2) begin
        n_vec++;
        if (if2.read_data !== ((k < 4) ? 32'h55 : 32'h66)) begin
          n_miss++; $display("FAIL mix data k=%0d: got %h want %h", k, if2.read_data, (k < 4) ? 32'h55 : 32'h66);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    s_en = 4'h0; s_we = 1'b0; s_addr = 16'h0; s_wdata = 32'h0; s_be = 4'h0;
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_stream_lat3();
    test_out_of_range();
    test_reset_mid_flight();
    test_back_to_back_mix();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
